// File: rtl/tlb_refill_ctrl.sv
// TLB refill sequencer: walks one PTE from memory per miss and writes the
// translation into a victim slot (first invalid slot, else round-robin).
module tlb_refill_ctrl #(
  parameter int NUM_ENTRIES = 8,
  parameter int IDX_W       = 3,
  parameter int ASID_W      = 6,
  parameter int VPN_W       = 8,
  parameter int PFN_W       = 8,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   miss_valid,
  input  logic [ASID_W-1:0]      miss_asid,
  input  logic [VPN_W-1:0]       miss_vpn,
  output logic                   miss_ready,
  input  logic [ADDR_W-1:0]      ptbr,
  input  logic [NUM_ENTRIES-1:0] tlb_valid_vec,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_ack,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic                   tlb_we,
  output logic [IDX_W-1:0]       tlb_idx,
  output logic                   tlb_v,
  output logic [ASID_W-1:0]      tlb_asid,
  output logic [VPN_W-1:0]       tlb_vpn,
  output logic [PFN_W-1:0]       tlb_pfn,
  output logic                   done,
  output logic                   fault,
  output logic [VPN_W-1:0]       fault_vpn,
  output logic                   busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WALK,
    S_FILL,
    S_DONE,
    S_FAULT
  } state_t;

  state_t            state_q, state_d;
  logic [ASID_W-1:0] asid_q, asid_d;
  logic [VPN_W-1:0]  vpn_q, vpn_d;
  logic [ADDR_W-1:0] ptbr_q, ptbr_d;
  logic [PFN_W-1:0]  pfn_q, pfn_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [VPN_W-1:0]  fault_vpn_q, fault_vpn_d;

  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  logic [ADDR_W-1:0] walk_addr;
  logic              rdata_unused;

  // Only the valid flag and the PFN field of the PTE are meaningful here.
  assign rdata_unused = ^mem_rdata[DATA_W-2:PFN_W];

  assign walk_addr = ptbr_q + ADDR_W'(vpn_q);

  // Scan from the top down so the lowest-numbered invalid slot wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!tlb_valid_vec[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    asid_d      = asid_q;
    vpn_d       = vpn_q;
    ptbr_d      = ptbr_q;
    pfn_d       = pfn_q;
    rr_d        = rr_q;
    fault_vpn_d = fault_vpn_q;

    miss_ready  = 1'b0;
    mem_req     = 1'b0;
    mem_addr    = '0;
    tlb_we      = 1'b0;
    tlb_idx     = '0;
    tlb_v       = 1'b0;
    tlb_asid    = '0;
    tlb_vpn     = '0;
    tlb_pfn     = '0;
    done        = 1'b0;
    fault       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) begin
          asid_d  = miss_asid;
          vpn_d   = miss_vpn;
          ptbr_d  = ptbr;
          state_d = S_WALK;
        end
      end
      S_WALK: begin
        mem_req  = 1'b1;
        mem_addr = walk_addr;
        if (mem_ack) begin
          pfn_d = mem_rdata[PFN_W-1:0];
          if (mem_rdata[DATA_W-1]) begin
            state_d = S_FILL;
          end else begin
            fault_vpn_d = vpn_q;
            state_d     = S_FAULT;
          end
        end
      end
      S_FILL: begin
        tlb_we   = 1'b1;
        tlb_v    = 1'b1;
        tlb_asid = asid_q;
        tlb_vpn  = vpn_q;
        tlb_pfn  = pfn_q;
        if (free_found) begin
          tlb_idx = free_idx;
        end else begin
          tlb_idx = rr_q;
          rr_d    = rr_q + 1'b1;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_FAULT: begin
        fault   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      asid_q      <= '0;
      vpn_q       <= '0;
      ptbr_q      <= '0;
      pfn_q       <= '0;
      rr_q        <= '0;
      fault_vpn_q <= '0;
    end else begin
      state_q     <= state_d;
      asid_q      <= asid_d;
      vpn_q       <= vpn_d;
      ptbr_q      <= ptbr_d;
      pfn_q       <= pfn_d;
      rr_q        <= rr_d;
      fault_vpn_q <= fault_vpn_d;
    end
  end

  assign fault_vpn = fault_vpn_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// Directed bench for tlb_refill_ctrl: a table of refill/fault vectors with
// hand-computed results plus reset-related sequences.
module tb_tlb_refill_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        miss_valid;
  logic [5:0]  miss_asid;
  logic [7:0]  miss_vpn;
  logic        miss_ready;
  logic [15:0] ptbr;
  logic [7:0]  tlb_valid_vec;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        tlb_we;
  logic [2:0]  tlb_idx;
  logic        tlb_v;
  logic [5:0]  tlb_asid;
  logic [7:0]  tlb_vpn;
  logic [7:0]  tlb_pfn;
  logic        done;
  logic        fault;
  logic [7:0]  fault_vpn;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tlb_refill_ctrl dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_asid(miss_asid), .miss_vpn(miss_vpn),
    .miss_ready(miss_ready), .ptbr(ptbr), .tlb_valid_vec(tlb_valid_vec),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .tlb_we(tlb_we), .tlb_idx(tlb_idx),
    .tlb_v(tlb_v), .tlb_asid(tlb_asid), .tlb_vpn(tlb_vpn),
    .tlb_pfn(tlb_pfn), .done(done), .fault(fault),
    .fault_vpn(fault_vpn), .busy(busy)
  );

  typedef struct {
    logic [15:0] ptbr;
    logic [5:0]  asid;
    logic [7:0]  vpn;
    logic [7:0]  vvec;
    logic [15:0] rdata;
    int          delay;     // WALK cycles without ack before the ack cycle
    logic [15:0] exp_addr;
    bit          exp_fault;
    logic [2:0]  exp_idx;
    logic [7:0]  exp_pfn;
    int          exp_lat;   // cycles from accept to done/fault pulse
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int n);
    vec_t v;
    int cyc, walk_cnt, we_cnt, ev_cyc;
    bit seen_end, seen_fault, multi_hot;
    logic [15:0] addr_seen;
    logic [2:0] idx_seen;
    logic [7:0] pfn_seen, vpn_seen;
    logic [5:0] asid_seen;
    v = vecs[n];
    walk_cnt = 0; we_cnt = 0; ev_cyc = -1; seen_end = 0; seen_fault = 0;
    multi_hot = 0; addr_seen = '0; idx_seen = '0; pfn_seen = '0;
    vpn_seen = '0; asid_seen = '0;

    @(negedge clk);
    chk($sformatf("v%0d_ready", n), miss_ready, 1'b1);
    miss_valid = 1'b1; ptbr = v.ptbr; miss_asid = v.asid; miss_vpn = v.vpn;
    tlb_valid_vec = v.vvec;
    @(negedge clk);
    // Scramble miss-side inputs; the walk must use the latched copies.
    miss_valid = 1'b0; ptbr = ~v.ptbr; miss_asid = ~v.asid; miss_vpn = ~v.vpn;
    cyc = 1;
    while (cyc < 40 && !seen_end) begin
      mem_ack = 1'b0;
      mem_rdata = 16'h8000 | 16'(cyc);
      if (mem_req) begin
        if (walk_cnt == 0) addr_seen = mem_addr;
        else if (mem_addr !== addr_seen || !busy) multi_hot = 1'b1;
        if (walk_cnt == v.delay) begin
          mem_ack = 1'b1;
          mem_rdata = v.rdata;
        end
        walk_cnt++;
      end
      if (tlb_we) begin
        we_cnt++;
        idx_seen = tlb_idx; pfn_seen = tlb_pfn; vpn_seen = tlb_vpn;
        asid_seen = tlb_asid;
        if (!tlb_v) multi_hot = 1'b1;
      end
      if (32'(tlb_we) + 32'(done) + 32'(fault) > 1) multi_hot = 1'b1;
      if (done || fault) begin
        seen_end = 1'b1; seen_fault = fault; ev_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    mem_ack = 1'b0;

    chk($sformatf("v%0d_timeout", n), seen_end, 1'b1);
    chk($sformatf("v%0d_consistency", n), multi_hot, 1'b0);
    chk($sformatf("v%0d_addr", n), addr_seen, v.exp_addr);
    chk($sformatf("v%0d_req_cycles", n), walk_cnt, v.delay + 1);
    chk($sformatf("v%0d_fault", n), seen_fault, v.exp_fault);
    chk($sformatf("v%0d_latency", n), ev_cyc, v.exp_lat);
    chk($sformatf("v%0d_idle_after", n), {busy, miss_ready}, 2'b01);
    if (v.exp_fault) begin
      chk($sformatf("v%0d_we_count", n), we_cnt, 0);
      chk($sformatf("v%0d_fault_vpn", n), fault_vpn, v.vpn);
    end else begin
      chk($sformatf("v%0d_we_count", n), we_cnt, 1);
      chk($sformatf("v%0d_idx", n), idx_seen, v.exp_idx);
      chk($sformatf("v%0d_pfn", n), pfn_seen, v.exp_pfn);
      chk($sformatf("v%0d_vpn", n), vpn_seen, v.vpn);
      chk($sformatf("v%0d_asid", n), asid_seen, v.asid);
    end
    $display("vec %0d: addr=%h req_cycles=%0d fault=%0d idx=%0d pfn=%h latency=%0d",
             n, addr_seen, walk_cnt, seen_fault, idx_seen, pfn_seen, ev_cyc);
  endtask

  initial begin
    int bad;
    //          ptbr     asid   vpn    vvec   rdata    dly addr     flt idx   pfn    lat
    vecs[0]  = '{16'h0200, 6'h09, 8'h00, 8'h00, 16'h8003, 0, 16'h0200, 0, 3'd0, 8'h03, 3};
    vecs[1]  = '{16'hFFF0, 6'h01, 8'h20, 8'h00, 16'h8011, 3, 16'h0010, 0, 3'd0, 8'h11, 6};
    vecs[2]  = '{16'h1000, 6'h3F, 8'h10, 8'hFF, 16'h80A0, 0, 16'h1010, 0, 3'd0, 8'hA0, 3};
    vecs[3]  = '{16'h1000, 6'h3F, 8'h11, 8'hFF, 16'h80A1, 1, 16'h1011, 0, 3'd1, 8'hA1, 4};
    vecs[4]  = '{16'h1000, 6'h3F, 8'h12, 8'hFF, 16'h80A2, 0, 16'h1012, 0, 3'd2, 8'hA2, 3};
    vecs[5]  = '{16'h2000, 6'h05, 8'h40, 8'hEF, 16'h8044, 0, 16'h2040, 0, 3'd4, 8'h44, 3};
    vecs[6]  = '{16'h2000, 6'h05, 8'h41, 8'hFF, 16'h8045, 0, 16'h2041, 0, 3'd3, 8'h45, 3};
    vecs[7]  = '{16'h0300, 6'h02, 8'hFF, 8'h7F, 16'h8077, 2, 16'h03FF, 0, 3'd7, 8'h77, 5};
    vecs[8]  = '{16'h0400, 6'h2A, 8'h7A, 8'h00, 16'h0005, 1, 16'h047A, 1, 3'd0, 8'h00, 3};
    vecs[9]  = '{16'h0500, 6'h11, 8'h05, 8'hFF, 16'hC0FF, 2, 16'h0505, 0, 3'd4, 8'hFF, 5};
    vecs[10] = '{16'hFF00, 6'h00, 8'hFF, 8'h01, 16'h8012, 0, 16'hFFFF, 0, 3'd1, 8'h12, 3};
    vecs[11] = '{16'h0000, 6'h00, 8'h33, 8'h00, 16'h7FFF, 0, 16'h0033, 1, 3'd0, 8'h00, 2};
    // Run after the mid-walk reset: round-robin pointer must be back at 0.
    vecs[12] = '{16'h0100, 6'h07, 8'h08, 8'hFF, 16'h8088, 0, 16'h0108, 0, 3'd0, 8'h88, 3};

    reset = 1'b1; miss_valid = 1'b0; miss_asid = '0; miss_vpn = '0;
    ptbr = '0; tlb_valid_vec = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", miss_ready, 1'b1);
    chk("rst_outputs", {mem_req, tlb_we, done, fault, busy}, 5'b0);
    chk("rst_fields", {mem_addr, fault_vpn, tlb_idx}, 27'b0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(i);

    // Reset in the middle of a walk; a late ack must not cause a fill.
    @(negedge clk);
    miss_valid = 1'b1; ptbr = 16'h0600; miss_asid = 6'h15; miss_vpn = 8'h01;
    tlb_valid_vec = 8'hFF;
    @(negedge clk);
    miss_valid = 1'b0;
    chk("midwalk_req", mem_req, 1'b1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midwalk_reset_req", mem_req, 1'b0);
    chk("midwalk_reset_state", {busy, miss_ready}, 2'b01);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 16'h8099;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (tlb_we || done || fault || mem_req || busy) bad++;
    end
    chk("late_ack_ignored", bad, 0);
    $display("midwalk reset: late ack produced %0d active cycles", bad);

    run_vec(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
